// File: rtl/chacha_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chacha_pkg : shared ChaCha20 types for engine, builder and XOR     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package chacha_pkg;
    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] chacha_matrix_t;

    localparam int WORDS_PER_BLOCK = 16;

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } ks_state_t;
endpackage
`default_nettype wire

// File: rtl/chacha_byte_mask.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chacha_byte_mask : expands 4 byte enables into a 32-bit lane mask  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module chacha_byte_mask
    import chacha_pkg::*;
(
    input  logic [3:0] keep,
    output word_t      mask
);
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign mask[8*i +: 8] = {8{keep[i]}};
    end
endmodule
`default_nettype wire

// File: rtl/chacha_keystream_xor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chacha_keystream_xor : buffers one keystream block and XORs it     |
// | word-by-word into a plaintext stream. Rev 1.0                      |
// +--------------------------------------------------------------------+
module chacha_keystream_xor
    import chacha_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  chacha_matrix_t   ks_block,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [31:0]      pt_data,
    input  logic [3:0]       pt_keep,
    input  logic             pt_last,
    input  logic             pt_valid,
    output logic             pt_ready,
    output logic [31:0]      ct_data,
    output logic [3:0]       ct_keep,
    output logic             ct_last,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [CNT_W-1:0] blk_count
);
    localparam logic [3:0]       c_LAST_IDX = 4'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    ks_state_t      r_state;
    chacha_matrix_t r_ks;
    logic [3:0]     r_idx;
    word_t          w_mask;
    word_t          w_ks_word;
    logic           w_fire;
    logic           w_release;
    logic           w_capture;

    chacha_byte_mask u_mask (
        .keep (pt_keep),
        .mask (w_mask)
    );

    // Row-major walk: idx[3:2] picks the row, idx[1:0] the column.
    assign w_ks_word = r_ks[r_idx[3:2]][r_idx[1:0]];

    assign pt_ready  = (r_state == LOADED) && (!ct_valid || ct_ready);
    assign w_fire    = pt_valid && pt_ready;
    assign w_release = w_fire && ((r_idx == c_LAST_IDX) || pt_last);
    // Opening the buffer during release lets a waiting block land with no bubble.
    assign ks_ready  = (r_state == EMPTY) || w_release;
    assign w_capture = ks_valid && ks_ready;

    // Keystream contents are don't-care until a capture, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_ks <= ks_block;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_idx     <= '0;
            ct_data   <= '0;
            ct_keep   <= '0;
            ct_last   <= 1'b0;
            ct_valid  <= 1'b0;
            blk_count <= '0;
        end else begin
            if (w_fire) begin
                ct_data  <= (pt_data ^ w_ks_word) & w_mask;
                ct_keep  <= pt_keep;
                ct_last  <= pt_last;
                ct_valid <= 1'b1;
            end else if (ct_ready) begin
                ct_valid <= 1'b0;
            end

            if (w_release) begin
                blk_count <= blk_count + c_CNT_ONE;
            end

            if (w_capture) begin
                r_state <= LOADED;
                r_idx   <= '0;
            end else if (w_release) begin
                r_state <= EMPTY;
                r_idx   <= '0;
            end else if (w_fire) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_chacha_keystream_xor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_chacha_keystream_xor : directed scoreboard bench for the XOR    |
// | stage, including the RFC 8439 sunscreen message. Rev 1.0           |
// +--------------------------------------------------------------------+
module tb_chacha_keystream_xor;
    import chacha_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    typedef logic [15:0][31:0] st_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    chacha_matrix_t ks_block = '0;
    logic           ks_valid = 1'b0;
    logic           ks_ready;
    logic [31:0]    pt_data = '0;
    logic [3:0]     pt_keep = '0;
    logic           pt_last = 1'b0;
    logic           pt_valid = 1'b0;
    logic           pt_ready;
    logic [31:0]    ct_data;
    logic [3:0]     ct_keep;
    logic           ct_last;
    logic           ct_valid;
    logic           ct_ready = 1'b1;
    logic [31:0]    blk_count;

    chacha_keystream_xor #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ks_block  (ks_block),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .pt_data   (pt_data),
        .pt_keep   (pt_keep),
        .pt_last   (pt_last),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .ct_data   (ct_data),
        .ct_keep   (ct_keep),
        .ct_last   (ct_last),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    int             n_vec = 0;
    int             n_bad = 0;
    exp_t           q[$];
    logic [31:0]    got[$];
    chacha_matrix_t m_ks = '0;
    int             m_idx = 0;
    logic           m_loaded = 1'b0;
    logic           m_ctv = 1'b0;
    logic           m_known = 1'b0;
    logic [31:0]    m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] keep_mask(input logic [3:0] k);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic chacha_matrix_t mk_blk(input logic [31:0] salt);
        chacha_matrix_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = 32'(32'h0101_0101 * (4*r + c)) ^ salt;
        return m;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic st_t qr(input st_t x, input int a, input int b, input int c, input int d);
        st_t y = x;
        y[a] = y[a] + y[b]; y[d] = rotl(y[d] ^ y[a], 16);
        y[c] = y[c] + y[d]; y[b] = rotl(y[b] ^ y[c], 12);
        y[a] = y[a] + y[b]; y[d] = rotl(y[d] ^ y[a], 8);
        y[c] = y[c] + y[d]; y[b] = rotl(y[b] ^ y[c], 7);
        return y;
    endfunction

    // ChaCha20 block for key 00..1f, nonce 00000000_0000004a_00000000.
    function automatic chacha_matrix_t chacha_block(input logic [31:0] ctr);
        st_t s;
        st_t x;
        chacha_matrix_t m;
        s[0] = 32'h6170_7865; s[1] = 32'h3320_646e;
        s[2] = 32'h7962_2d32; s[3] = 32'h6b20_6574;
        for (int i = 0; i < 8; i++)
            s[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        s[12] = ctr; s[13] = 32'h0; s[14] = 32'h4a00_0000; s[15] = 32'h0;
        x = s;
        for (int r = 0; r < 10; r++) begin
            x = qr(x, 0, 4, 8, 12);  x = qr(x, 1, 5, 9, 13);
            x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
            x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
            x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) m[i/4][i%4] = x[i] + s[i];
        return m;
    endfunction

    // One clock: check outputs against the model, update scoreboard, advance.
    task automatic step();
        logic exp_ptr, exp_ksr, fire, rel, cap;
        exp_t e;
        #1;
        exp_ptr = m_loaded && (!m_ctv || ct_ready);
        fire    = pt_valid && exp_ptr;
        rel     = fire && ((m_idx == 15) || pt_last);
        exp_ksr = !m_loaded || rel;
        cap     = ks_valid && exp_ksr;
        if (m_known) begin
            chk("pt_ready", 32'(pt_ready), 32'(exp_ptr));
            chk("ks_ready", 32'(ks_ready), 32'(exp_ksr));
            chk("ct_valid", 32'(ct_valid), 32'(m_ctv));
            chk("blk_count", blk_count, m_cnt);
            if (m_ctv) begin
                chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    chk("ct_data", ct_data, q[0].data);
                    chk("ct_keep", 32'(ct_keep), 32'(q[0].keep));
                    chk("ct_last", 32'(ct_last), 32'(q[0].last));
                end
            end
        end
        if (m_ctv && ct_ready && q.size() > 0) begin
            got.push_back(ct_data);
            e = q.pop_front();
        end
        if (fire) begin
            e.data = (pt_data ^ m_ks[m_idx/4][m_idx%4]) & keep_mask(pt_keep);
            e.keep = pt_keep;
            e.last = pt_last;
            q.push_back(e);
        end
        m_ctv = fire ? 1'b1 : (ct_ready ? 1'b0 : m_ctv);
        if (rel) begin
            m_idx = 0; m_cnt = m_cnt + 32'd1; m_loaded = 1'b0;
        end else if (fire) begin
            m_idx = m_idx + 1;
        end
        if (cap) begin
            m_ks = ks_block; m_loaded = 1'b1; m_idx = 0;
        end
        @(negedge clk);
        if (rst) begin
            m_loaded = 1'b0; m_ctv = 1'b0; m_idx = 0; m_cnt = '0;
            q.delete();
            m_known = 1'b1;
        end
    endtask

    task automatic word(input logic [31:0] d, input logic [3:0] k, input logic l);
        pt_data = d; pt_keep = k; pt_last = l; pt_valid = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        pt_valid = 1'b0; pt_last = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input chacha_matrix_t b);
        ks_block = b; ks_valid = 1'b1;
        step();
        ks_valid = 1'b0;
    endtask

    function automatic logic [31:0] msg_word(input string s, input int w);
        logic [31:0] v = '0;
        for (int b = 0; b < 4; b++)
            if (4*w + b < s.len()) v[8*b +: 8] = s[4*w + b];
        return v;
    endfunction

    initial begin
        chacha_matrix_t a, b, c, b1, b2;
        string msg;
        int base;
        msg = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";

        @(negedge clk);
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst_ct_valid", 32'(ct_valid), 32'd0);
        chk("rst_ct_data", ct_data, 32'd0);
        chk("rst_ct_keep", 32'(ct_keep), 32'd0);
        chk("rst_ct_last", 32'(ct_last), 32'd0);
        chk("rst_blk_count", blk_count, 32'd0);
        chk("rst_ks_ready", 32'(ks_ready), 32'd1);
        chk("rst_pt_ready", 32'(pt_ready), 32'd0);

        // Full block of all-ones plaintext: ciphertext is the inverted keystream.
        a = mk_blk(32'h0);
        load(a);
        got.delete();
        ct_ready = 1'b1;
        for (int k = 0; k < 16; k++) word(32'hFFFF_FFFF, 4'hF, 1'b0);
        idle(2);
        chk("t1_word0", got[0], 32'hFFFF_FFFF);
        chk("t1_word5", got[5], ~32'h0505_0505);
        chk("t1_word15", got[15], ~32'h0F0F_0F0F);
        chk("t1_blk_count", blk_count, 32'd1);
        chk("t1_ks_ready", 32'(ks_ready), 32'd1);

        // Backpressure after the first fire stalls pt and holds ct.
        a = mk_blk(32'h5A5A_0F0F);
        load(a);
        got.delete();
        ct_ready = 1'b0;
        word(32'h1111_1111, 4'hF, 1'b0);
        pt_data = 32'h2222_2222;
        for (int i = 0; i < 5; i++) step();
        chk("bp_pt_ready", 32'(pt_ready), 32'd0);
        chk("bp_ct_hold", ct_data, 32'h1111_1111 ^ a[0][0]);
        ct_ready = 1'b1;
        word(32'h2222_2222, 4'hF, 1'b0);
        word(32'h3333_3333, 4'hF, 1'b0);
        word(32'h4444_4444, 4'hF, 1'b1);
        idle(2);
        chk("bp_resume_idx1", got[1], 32'h2222_2222 ^ a[0][1]);
        chk("bp_blk_count", blk_count, 32'd2);

        // Back-to-back: block b offered during the idx 15 fire of block a.
        a = mk_blk(32'hDEAD_0000);
        b = mk_blk(32'h0000_BEEF);
        load(a);
        got.delete();
        for (int k = 0; k < 15; k++) word(32'(k) * 32'h0102_0304, 4'hF, 1'b0);
        ks_block = b; ks_valid = 1'b1;
        word(32'hCAFE_F00D, 4'hF, 1'b0);
        ks_valid = 1'b0;
        chk("b2b_pt_ready", 32'(pt_ready), 32'd1);
        word(32'h7654_3210, 4'hF, 1'b0);
        word(32'h0F1E_2D3C, 4'hF, 1'b1);
        idle(2);
        chk("b2b_word15", got[15], 32'hCAFE_F00D ^ a[3][3]);
        chk("b2b_word16", got[16], 32'h7654_3210 ^ b[0][0]);
        chk("b2b_blk_count", blk_count, 32'd4);

        // Early last at idx 3 discards the rest of the block.
        a = mk_blk(32'h1357_9BDF);
        c = mk_blk(32'hFEDC_BA98);
        load(a);
        got.delete();
        for (int k = 0; k < 3; k++) word(32'hA0A0_A0A0 + 32'(k), 4'hF, 1'b0);
        word(32'h0000_BBBB, 4'h3, 1'b1);
        chk("early_ks_ready", 32'(ks_ready), 32'd1);
        idle(1);
        load(c);
        word(32'h5555_AAAA, 4'hF, 1'b1);
        idle(2);
        chk("early_tail_mask", got[3], (32'h0000_BBBB ^ a[0][3]) & 32'h0000_FFFF);
        chk("early_new_blk", got[4], 32'h5555_AAAA ^ c[0][0]);

        // Reset mid-message at idx 7 with a pending ct word.
        load(mk_blk(32'h0BAD_F00D));
        for (int k = 0; k < 7; k++) word(32'h1234_0000 + 32'(k), 4'hF, 1'b0);
        pt_valid = 1'b0;
        ct_ready = 1'b0;
        chk("rst7_ct_valid_pre", 32'(ct_valid), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst7_ct_valid", 32'(ct_valid), 32'd0);
        chk("rst7_pt_ready", 32'(pt_ready), 32'd0);
        chk("rst7_ks_ready", 32'(ks_ready), 32'd1);
        chk("rst7_blk_count", blk_count, 32'd0);
        ct_ready = 1'b1;

        // RFC 8439 sunscreen message, keystream counters 1 and 2.
        b1 = chacha_block(32'd1);
        b2 = chacha_block(32'd2);
        load(b1);
        got.delete();
        ks_block = b2; ks_valid = 1'b1;
        base = 0;
        for (int w = 0; w < 16; w++) word(msg_word(msg, w), 4'hF, 1'b0);
        ks_valid = 1'b0;
        for (int w = 16; w < 28; w++) word(msg_word(msg, w), 4'hF, 1'b0);
        word(msg_word(msg, 28), 4'b0011, 1'b1);
        idle(3);
        chk("rfc_count", 32'(got.size()), 32'd29);
        if (got.size() == 29) begin
            chk("rfc_first", got[base], 32'h9a35_2e6e);
            chk("rfc_last", got[28], 32'h0000_4d87);
        end
        chk("rfc_blk_count", blk_count, 32'd2);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
